// File: rtl/mem_responder.sv
// Memory-side responder: RAM and switch/LED I/O behind the CPU mem_cmd bus,
// registered read data with a one-cycle valid pulse, sticky error and access counters.
module mem_responder #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 9,
  parameter int                MEM_WORDS = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [7:0]        sw,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic [7:0]        led,
  output logic              err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_RSV = 2'b11;

  typedef enum logic {IDLE, RD_RESP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [7:0]        led_q, led_d;
  logic              err_q, err_d;
  logic [15:0]       rd_count_q, rd_count_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [7:0]        sw_meta_q, sw_sync_q;
  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  logic              is_ram, is_led, is_sw;
  logic [IDX_W-1:0]  ram_idx;
  logic [DATA_W-1:0] rd_src;
  logic              rd_err;
  logic              ram_we;

  // Zero-extended compare so unmapped addresses can never alias into the RAM index
  always_comb begin
    is_ram  = ({{(32-ADDR_W){1'b0}}, mem_addr} < 32'(MEM_WORDS));
    is_led  = (mem_addr == LED_ADDR);
    is_sw   = (mem_addr == SW_ADDR);
    ram_idx = mem_addr[IDX_W-1:0];
    rd_src  = '0;
    rd_err  = 1'b0;
    if (is_ram) begin
      rd_src = mem_q[ram_idx];
    end else if (is_sw) begin
      rd_src = {{(DATA_W-8){1'b0}}, sw_sync_q};
    end else begin
      rd_err = 1'b1;
    end
  end

  assign ram_we   = (mem_cmd == CMD_WR) && is_ram;
  assign rd_valid = (state_q == RD_RESP);

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    led_d       = led_q;
    err_d       = err_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;

    case (state_q)
      IDLE: begin
        if (mem_cmd == CMD_RD) begin
          read_data_d = rd_src;
          state_d     = RD_RESP;
        end
      end
      RD_RESP: begin
        if (mem_cmd == CMD_RD) begin
          read_data_d = rd_src;
          state_d     = RD_RESP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (mem_cmd == CMD_RD && rd_err) begin
      err_d = 1'b1;
    end

    if (mem_cmd == CMD_WR) begin
      if (wr_count_q != 16'hFFFF) begin
        wr_count_d = wr_count_q + 16'd1;
      end
      if (is_led) begin
        led_d = write_data[7:0];
      end else if (!is_ram) begin
        err_d = 1'b1;
      end
    end

    if (mem_cmd == CMD_RSV) begin
      err_d = 1'b1;
    end

    if (rd_valid && rd_count_q != 16'hFFFF) begin
      rd_count_d = rd_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      read_data_q <= '0;
      led_q       <= '0;
      err_q       <= 1'b0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      led_q       <= led_d;
      err_q       <= err_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      sw_meta_q   <= sw;
      sw_sync_q   <= sw_meta_q;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_idx] <= write_data;
    end
  end

  assign read_data = read_data_q;
  assign led       = led_q;
  assign err       = err_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed commands; read responses checked by a
// scoreboard monitor, status outputs checked directly after each step.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [7:0]  sw;
  logic [15:0] read_data;
  logic        rd_valid;
  logic [7:0]  led;
  logic        err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  localparam int SAT_WRITES = 65540;

  mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .sw         (sw),
    .read_data  (read_data),
    .rd_valid   (rd_valid),
    .led        (led),
    .err        (err),
    .rd_count   (rd_count),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest expected read
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got pulse data %0h expected no pulse (t=%0t)", read_data, $time);
      end else begin
        chk("rd_data", {16'h0, read_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_cmd = 2'b00;
    step();
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    mem_cmd    = 2'b10;
    mem_addr   = a;
    write_data = d;
    step();
  endtask

  task automatic rd(input logic [8:0] a, input logic [15:0] e);
    exp_q.push_back(e);
    mem_cmd  = 2'b01;
    mem_addr = a;
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] last_d;
    rst        = 1'b0;
    mem_cmd    = 2'b00;
    mem_addr   = '0;
    write_data = '0;
    sw         = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_data", {16'h0, read_data}, 32'h0);
    chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rd_count", {16'h0, rd_count}, 32'h0);
    chk("rst_wr_count", {16'h0, wr_count}, 32'h0);
    rst = 1'b1;
    idle();
    chk("post_rst_rd_valid", {31'h0, rd_valid}, 32'h0);

    wr(9'h005, 16'hBEEF);
    rd(9'h005, 16'hBEEF);
    idle();
    chk("raw_wr_count", {16'h0, wr_count}, 32'd1);
    chk("raw_rd_count", {16'h0, rd_count}, 32'd1);

    wr(9'h000, 16'h1111);
    wr(9'h0FF, 16'h2222);
    rd(9'h000, 16'h1111);
    chk("b2b_valid_1", {31'h0, rd_valid}, 32'h1);
    rd(9'h0FF, 16'h2222);
    chk("b2b_valid_2", {31'h0, rd_valid}, 32'h1);
    idle();
    chk("b2b_rd_count", {16'h0, rd_count}, 32'd3);
    chk("b2b_wr_count", {16'h0, wr_count}, 32'd3);

    wr(9'h100, 16'h12A5);
    chk("led_write", {24'h0, led}, 32'hA5);
    chk("err_clean", {31'h0, err}, 32'h0);
    sw = 8'h3C;
    idle();
    idle();
    rd(9'h140, 16'h003C);
    idle();

    rd(9'h180, 16'h0000);
    chk("err_unmapped_rd", {31'h0, err}, 32'h1);
    rd(9'h100, 16'h0000);
    wr(9'h140, 16'h5555);
    wr(9'h1FF, 16'h7777);
    wr(9'h105, 16'h7777);
    chk("led_unchanged", {24'h0, led}, 32'hA5);
    rd(9'h140, 16'h003C);
    rd(9'h0FF, 16'h2222);
    rd(9'h005, 16'hBEEF);
    mem_cmd = 2'b11;
    step();
    chk("rsv_rd_count", {16'h0, rd_count}, 32'd9);
    chk("rsv_wr_count", {16'h0, wr_count}, 32'd7);
    chk("rsv_led", {24'h0, led}, 32'hA5);
    chk("rsv_err", {31'h0, err}, 32'h1);

    repeat (3) wr(9'h007, 16'h0ABC);
    rd(9'h007, 16'h0ABC);
    idle();
    chk("hold_wr_count", {16'h0, wr_count}, 32'd10);
    chk("hold_rd_count", {16'h0, rd_count}, 32'd10);

    for (int i = 0; i < SAT_WRITES; i++) begin
      wr(9'h003, 16'(i));
    end
    chk("sat_wr_count", {16'h0, wr_count}, 32'hFFFF);
    last_d = 16'(SAT_WRITES - 1);
    rd(9'h003, last_d);
    idle();

    mem_cmd  = 2'b01;
    mem_addr = 9'h005;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    mem_cmd = 2'b00;
    #1;
    chk("midrd_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("midrd_read_data", {16'h0, read_data}, 32'h0);
    chk("midrd_wr_count", {16'h0, wr_count}, 32'h0);
    chk("midrd_led", {24'h0, led}, 32'h0);
    chk("midrd_err", {31'h0, err}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle();
    idle();
    chk("midrd_rd_count", {16'h0, rd_count}, 32'h0);

    mem_cmd = 2'b11;
    step();
    chk("rsv_sets_err", {31'h0, err}, 32'h1);
    chk("rsv_no_write", {16'h0, wr_count}, 32'h0);
    rd(9'h005, 16'hBEEF);
    idle();
    chk("final_rd_count", {16'h0, rd_count}, 32'd1);
    idle();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
